smooth_mac_sequencer: RTL and testbench

Parametrised control sequencer for the smoothing datapath. On each `ready` pulse it walks every channel through an optional accumulator clear/load, a runtime-selectable number of multiply-accumulate taps and a one-cycle output strobe, driving tap address, coefficient select, channel select and accumulator controls. It sits between the sample-ready source and the shared MAC/accumulator datapath. It replaces the fixed two-tap, single-channel controller with configurable tap depth, multiple channels, a busy/overrun handshake and an asynchronous reset.

---
 rtl/smooth_pkg.sv | 30 +++
 rtl/smooth_mac_sequencer_if.sv | 31 +++
 rtl/smooth_tap_counter.sv | 35 +++
 rtl/smooth_mac_sequencer.sv | 118 +++++++++++
 tb/tb_smooth_mac_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/smooth_pkg.sv
// Shared definitions for the smoothing datapath: state/mode encodings,
// parameter limits and the tap-count clamp used when a run is latched.
package smooth_pkg;

    localparam int unsigned NTAPS_MIN = 2;
    localparam int unsigned NTAPS_MAX = 16;
    localparam int unsigned NCH_MIN   = 1;
    localparam int unsigned NCH_MAX   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RAW    = 2'd1,
        MODE_SMOOTH = 2'd2
    } mode_e;

    // Zero taps still performs one MAC; anything beyond the buffer depth saturates.
    function automatic int unsigned clamp_taps(input int unsigned cfg, input int unsigned ntaps);
        if (cfg == 0) return 1;
        if (cfg > ntaps) return ntaps;
        return cfg;
    endfunction

endpackage

// File: rtl/smooth_mac_sequencer_if.sv
// Control bus between the sample-ready source and the MAC sequencer.
interface smooth_mac_sequencer_if #(
    parameter int unsigned NTAPS = 4,
    parameter int unsigned NCH   = 2,
    parameter int unsigned TAP_W = $clog2(NTAPS),
    parameter int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic             ready;
    logic             stage1;
    logic             smooth;
    logic [TAP_W:0]   taps_cfg;
    logic             busy;
    logic             acc_clr;
    logic             mac_en;
    logic [TAP_W-1:0] tap_addr;
    logic [TAP_W-1:0] factor_sel;
    logic [CH_W-1:0]  ch_sel;
    logic             out_en;
    logic             overrun;

    modport master (
        output ready, stage1, smooth, taps_cfg,
        input  busy, acc_clr, mac_en, tap_addr, factor_sel, ch_sel, out_en, overrun
    );

    modport slave (
        input  ready, stage1, smooth, taps_cfg,
        output busy, acc_clr, mac_en, tap_addr, factor_sel, ch_sel, out_en, overrun
    );

endinterface

// File: rtl/smooth_tap_counter.sv
// Loadable up/down tap counter with a terminal-count compare against tc_val.
module smooth_tap_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = up ? cnt_q + W'(1) : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/smooth_mac_sequencer.sv
// Per-run sequencer: walks every channel through LOAD / MAC taps / OUT and
// drives the shared MAC datapath controls from registered state decodes.
module smooth_mac_sequencer
    import smooth_pkg::*;
#(
    parameter int unsigned NTAPS = 4,
    parameter int unsigned NCH   = 2
) (
    input logic                   sys_clk,
    input logic                   reset_n,
    smooth_mac_sequencer_if.slave bus
);

    localparam int unsigned TAP_W  = $clog2(NTAPS);
    localparam int unsigned TAPC_W = TAP_W + 1;
    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [TAPC_W-1:0]  taps_q, taps_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               busy_q, busy_d;
    logic               acc_clr_q, acc_clr_d;
    logic               mac_en_q, mac_en_d;
    logic               out_en_q, out_en_d;
    logic               overrun_q, overrun_d;

    logic [TAP_W-1:0]   tap_cnt;
    logic               tap_tc;
    logic               tap_load;

    // The counter only advances between consecutive MAC cycles, so it reads
    // 0 on MAC entry and everywhere outside the MAC phase.
    assign tap_load = !((state_q == ST_MAC) && (state_d == ST_MAC));

    smooth_tap_counter #(.W(TAP_W)) u_tap_cnt (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .load     (tap_load),
        .en       (1'b1),
        .up       (1'b1),
        .load_val ('0),
        .tc_val   (TAP_W'(taps_q - TAPC_W'(1))),
        .cnt      (tap_cnt),
        .tc       (tap_tc)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        taps_d  = taps_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ready) begin
                    mode_d  = bus.stage1 ? MODE_BYPASS : (bus.smooth ? MODE_SMOOTH : MODE_RAW);
                    taps_d  = TAPC_W'(clamp_taps(32'(bus.taps_cfg), NTAPS));
                    ch_d    = '0;
                    state_d = bus.stage1 ? ST_OUT : ST_LOAD;
                end
            end
            ST_LOAD: state_d = (mode_q == MODE_SMOOTH) ? ST_MAC : ST_OUT;
            ST_MAC: begin
                if (tap_tc) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (ch_q != CH_W'(NCH - 1)) begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = (mode_q == MODE_BYPASS) ? ST_OUT : ST_LOAD;
                end else begin
                    ch_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        acc_clr_d = (state_d == ST_LOAD);
        mac_en_d  = (state_d == ST_MAC);
        out_en_d  = (state_d == ST_OUT);
        overrun_d = bus.ready && (state_q != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_BYPASS;
            taps_q    <= '0;
            ch_q      <= '0;
            busy_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            out_en_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            taps_q    <= taps_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            acc_clr_q <= acc_clr_d;
            mac_en_q  <= mac_en_d;
            out_en_q  <= out_en_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.acc_clr    = acc_clr_q;
    assign bus.mac_en     = mac_en_q;
    assign bus.out_en     = out_en_q;
    assign bus.overrun    = overrun_q;
    assign bus.tap_addr   = tap_cnt;
    assign bus.factor_sel = tap_cnt;
    assign bus.ch_sel     = ch_q;

endmodule

// File: tb/tb_smooth_mac_sequencer.sv
// Scoreboard bench: a per-cycle expected output record is queued when ready is
// driven and compared against every DUT output on each falling clock edge.
module tb_smooth_mac_sequencer;

    localparam int unsigned NTAPS = 4;
    localparam int unsigned NCH   = 2;
    localparam int unsigned TAP_W = $clog2(NTAPS);
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic             busy;
        logic             acc_clr;
        logic             mac_en;
        logic             out_en;
        logic             ovr;
        logic [TAP_W-1:0] tap;
        logic [TAP_W-1:0] fsel;
        logic [CH_W-1:0]  ch;
    } rec_t;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;

    rec_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    smooth_mac_sequencer_if #(.NTAPS(NTAPS), .NCH(NCH)) sif ();

    smooth_mac_sequencer #(.NTAPS(NTAPS), .NCH(NCH)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic rec_t observe();
        rec_t r;
        r = {sif.busy, sif.acc_clr, sif.mac_en, sif.out_en, sif.overrun,
             sif.tap_addr, sif.factor_sel, sif.ch_sel};
        return r;
    endfunction

    // Expected cycles of one run, straight from the channel/phase description.
    function automatic void push_run(input logic s1, input logic sm, input int unsigned cfg);
        int unsigned t;
        rec_t r;
        t = (cfg == 0) ? 1 : ((cfg > NTAPS) ? NTAPS : cfg);
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!s1) begin
                r = '0; r.busy = 1'b1; r.acc_clr = 1'b1; r.ch = CH_W'(c);
                exp_q.push_back(r);
                if (sm) begin
                    for (int unsigned k = 0; k < t; k++) begin
                        r = '0; r.busy = 1'b1; r.mac_en = 1'b1;
                        r.tap = TAP_W'(k); r.fsel = TAP_W'(k); r.ch = CH_W'(c);
                        exp_q.push_back(r);
                    end
                end
            end
            r = '0; r.busy = 1'b1; r.out_en = 1'b1; r.ch = CH_W'(c);
            exp_q.push_back(r);
        end
    endfunction

    // Called at posedge+1 of cycle c; exp_q then holds records for cycles c onward.
    task automatic pulse_ready(input logic s1, input logic sm, input logic [TAP_W:0] cfg);
        rec_t r;
        if (exp_q.size() == 0) begin
            exp_q.push_back('0);
            push_run(s1, sm, 32'(cfg));
        end else if (exp_q.size() == 1) begin
            r = '0; r.ovr = 1'b1;
            exp_q.push_back(r);
        end else begin
            r = exp_q[1]; r.ovr = 1'b1; exp_q[1] = r;
        end
        sif.stage1   = s1;
        sif.smooth   = sm;
        sif.taps_cfg = cfg;
        sif.ready    = 1'b1;
        @(posedge sys_clk); #1;
        sif.ready    = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge sys_clk);
            n++;
        end
        #1;
        if (exp_q.size() > 0) begin
            check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge sys_clk); #1;
    endtask

    always @(negedge sys_clk) begin
        rec_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check_eq($sformatf("cyc%0d", cyc), 32'(observe()), 32'(e));
        cyc++;
    end

    initial begin
        sif.ready    = 1'b0;
        sif.stage1   = 1'b0;
        sif.smooth   = 1'b0;
        sif.taps_cfg = '0;

        repeat (2) @(posedge sys_clk);
        #1;
        check_eq("reset_outputs", 32'(observe()), 32'd0);
        reset_n = 1'b1;
        @(posedge sys_clk); #1;

        pulse_ready(1'b0, 1'b1, 3'd4); wait_drain();   // smooth, T=4
        pulse_ready(1'b1, 1'b1, 3'd4); wait_drain();   // bypass, smooth ignored
        pulse_ready(1'b0, 1'b0, 3'd4); wait_drain();   // raw
        pulse_ready(1'b0, 1'b1, 3'd0); wait_drain();   // taps 0 -> 1
        pulse_ready(1'b0, 1'b1, 3'd7); wait_drain();   // taps NTAPS+3 -> NTAPS
        pulse_ready(1'b0, 1'b1, 3'd2); wait_drain();

        // Overrun at cycle 3 and in the final OUT (cycle 12), with changed inputs
        pulse_ready(1'b0, 1'b1, 3'd4);
        repeat (2) begin @(posedge sys_clk); #1; end
        pulse_ready(1'b1, 1'b0, 3'd1);
        repeat (8) begin @(posedge sys_clk); #1; end
        pulse_ready(1'b0, 1'b0, 3'd3);
        wait_drain();

        // Reset asserted asynchronously during MAC k=2
        pulse_ready(1'b0, 1'b1, 3'd4);
        repeat (3) @(posedge sys_clk);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("reset_mid_mac", 32'(observe()), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        @(posedge sys_clk); #1;
        pulse_ready(1'b0, 1'b1, 3'd3); wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
